param_shift_reg: RTL
====================

PARAM_SHIFT_REG -- requirements
Module: param_shift_reg

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning register width in bits (legal range 2 to 64).
REQ-002 The block SHALL have parameter CNT_W, default 4, meaning width of the burst step count.
REQ-003 The block SHALL derive AW = clog2(WIDTH)+1, so that amt can encode WIDTH.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port load_n, input, 1 bit: active-low parallel load.
REQ-007 The block SHALL have port data_in, input, WIDTH bits: the parallel load value.
REQ-008 The block SHALL have port mode, input, 3 bits, with these encodings:
- 000 hold
- 001 logical shift left
- 010 logical shift right
- 011 arithmetic shift right
- 100 rotate left
- 101 rotate right
- 110 shift left with ser_in fill
- 111 shift right with ser_in fill
REQ-009 The block SHALL have port amt, input, AW bits: bit distance per step.
REQ-010 The block SHALL have port ser_in, input, 1 bit: fill value for modes 110 and 111.
REQ-011 The block SHALL have port en, input, 1 bit: perform one manual step (idle only).
REQ-012 The block SHALL have port start, input, 1 bit: begin an automatic burst.
REQ-013 The block SHALL have port steps, input, CNT_W bits: number of steps in a burst.
REQ-014 The block SHALL have port q, output, WIDTH bits: register contents.
REQ-015 The block SHALL have port ser_out, output, 1 bit: the last bit moved across the register boundary.
REQ-016 The block SHALL have port busy, output, 1 bit: high while a burst is running.
REQ-017 The block SHALL have port done, output, 1 bit: one-cycle pulse at burst completion.

Function
REQ-018 The block SHALL apply per-cycle priority: reset, then load_n=0, then start (idle only), then burst step, then en (idle only).
REQ-019 The block SHALL, on load_n=0, set q=data_in on the next edge, leave ser_out unchanged, and return the FSM to IDLE.
REQ-020 The block SHALL, for shift modes (001, 010, 011, 110, 111), treat amt>WIDTH as amt=WIDTH.
- 001/010: the result is all zeros at amt=WIDTH.
- 011: vacated bits fill with q[WIDTH-1]; the result is all sign bits at amt=WIDTH.
- 110/111: vacated bits fill with ser_in.
REQ-021 The block SHALL, for rotate modes (100, 101), use amt modulo WIDTH.
REQ-022 The block SHALL, for amt=0 or mode 000, leave q and ser_out unchanged by that step.
REQ-023 The block SHALL update ser_out on each non-null step as follows:
- Left shifts: pre-step q[WIDTH-amt].
- Right shifts: pre-step q[amt-1].
- Rotate left: post-step q[0].
- Rotate right: post-step q[WIDTH-1].
REQ-024 The block SHALL implement FSM states IDLE, RUN and FIN.
REQ-025 The block SHALL, on start in IDLE with steps=N>0, latch mode, amt and N, then enter RUN.
- busy=1 for exactly N cycles starting the cycle after start.
- One step executes per RUN cycle using the latched mode and amt.
REQ-026 The block SHALL, after the Nth step, enter FIN for one cycle with done=1 and busy=0, then return to IDLE.
REQ-027 The block SHALL, on start in IDLE with steps=0, go directly to FIN with q unchanged, giving done=1 in the following cycle.
REQ-028 The block SHALL ignore start and en while in RUN or FIN.
REQ-029 The block SHALL treat load_n=0 during RUN as an abort: load q, go to IDLE, busy=0 next cycle, and emit no done pulse.
REQ-030 The block SHALL, on en=1 in IDLE without start, perform one step using the live mode and amt on the next edge.
REQ-031 The block SHALL, on simultaneous start and en in IDLE, take start; en is discarded.
REQ-032 The block SHALL let changes to mode, amt and steps during RUN have no effect on the running burst.

Reset
REQ-033 The block SHALL, on reset=1 at a clk edge, set q=0, ser_out=0, busy=0, done=0 and FSM=IDLE, regardless of any other input.
REQ-034 The block SHALL treat reset during RUN as a burst abort with no done pulse.

Verification
REQ-035 The bench SHALL cover reset: reset=1 with load_n=0 and data_in=0xFF -> q=0x00, busy=0, done=0, ser_out=0.
REQ-036 The bench SHALL cover rotate right: load 0xA5, then mode=101, amt=1, en pulse -> q=0xD2, ser_out=1.
REQ-037 The bench SHALL cover arithmetic shift right: load 0x96, then mode=011, amt=3, en pulse -> q=0xF2, ser_out=1.
REQ-038 The bench SHALL cover a rotate burst: load 0x81, then start with steps=4, mode=100, amt=1 -> busy high 4 cycles, q=0x18, a single done pulse.
REQ-039 The bench SHALL cover a burst abort: start with steps=10, mode=001, amt=1 on q=0x01; at RUN cycle 3 drive load_n=0 with data_in=0x3C -> q=0x3C, busy=0, no done.
REQ-040 The bench SHALL cover the boundary cases:
- steps=0 -> done the next cycle, q unchanged.
- start while busy -> ignored.
- mode=001, amt=9 on 0xFF -> q=0x00, ser_out=1.

Source files
------------

// File: rtl/param_shift_reg.sv
// Parameterised shift/rotate register with manual single steps and counted
// automatic bursts. A small IDLE/RUN/FIN controller sequences the bursts.
// Each step moves the register by a programmable distance and records in
// ser_out the last bit that crossed the register boundary.
module param_shift_reg #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4,
  localparam int AW = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_n,
  input  logic [WIDTH-1:0] data_in,
  input  logic [2:0]       mode,
  input  logic [AW-1:0]    amt,
  input  logic             ser_in,
  input  logic             en,
  input  logic             start,
  input  logic [CNT_W-1:0] steps,
  output logic [WIDTH-1:0] q,
  output logic             ser_out,
  output logic             busy,
  output logic             done
);

  localparam logic [2:0] M_HOLD = 3'b000;
  localparam logic [2:0] M_LSL  = 3'b001;
  localparam logic [2:0] M_LSR  = 3'b010;
  localparam logic [2:0] M_ASR  = 3'b011;
  localparam logic [2:0] M_ROL  = 3'b100;
  localparam logic [2:0] M_ROR  = 3'b101;
  localparam logic [2:0] M_FSL  = 3'b110;
  localparam logic [2:0] M_FSR  = 3'b111;

  // The register width expressed in the amount encoding; AW always has
  // room for it, which is what makes the clamp below exact.
  localparam logic [AW-1:0]    W_AMT   = AW'(WIDTH);
  localparam logic [AW-1:0]    A_ONE   = AW'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic               ser_q, ser_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2:0]         mode_q, mode_d;
  logic [AW-1:0]      amt_q, amt_d;

  logic               idle_start;
  logic [WIDTH:0]     live_step;
  logic [WIDTH:0]     run_step;

  // One step of the shifter: returns {ser_out_next, q_next}.
  // Shift distances saturate at WIDTH; rotate distances wrap modulo WIDTH.
  // A zero distance or the hold mode leaves both register and ser_out alone.
  function automatic logic [WIDTH:0] step_fn(
    input logic [WIDTH-1:0] cur,
    input logic             cur_ser,
    input logic [2:0]       m,
    input logic [AW-1:0]    a,
    input logic             fill
  );
    logic [AW-1:0]    sa;
    logic [AW-1:0]    ra;
    logic [WIDTH-1:0] ones;
    logic [WIDTH-1:0] fill_lo;
    logic [WIDTH-1:0] fill_hi;
    logic [WIDTH-1:0] tap;
    logic [WIDTH-1:0] nxt;
    logic             ser;
    sa      = (a > W_AMT) ? W_AMT : a;
    ra      = a % W_AMT;
    ones    = '1;
    // Vacated positions for the serial-fill modes: low bits on a left
    // shift, high bits on a right shift.
    fill_lo = fill ? ~(ones << sa) : '0;
    fill_hi = fill ? ~(ones >> sa) : '0;
    tap     = '0;
    nxt     = cur;
    ser     = cur_ser;
    if (a != '0) begin
      case (m)
        M_LSL, M_FSL: begin
          nxt = (cur << sa) | ((m == M_FSL) ? fill_lo : '0);
          tap = cur >> (W_AMT - sa);
          ser = tap[0];
        end
        M_LSR, M_FSR: begin
          nxt = (cur >> sa) | ((m == M_FSR) ? fill_hi : '0);
          tap = cur >> (sa - A_ONE);
          ser = tap[0];
        end
        M_ASR: begin
          nxt = $signed(cur) >>> sa;
          tap = cur >> (sa - A_ONE);
          ser = tap[0];
        end
        M_ROL: begin
          nxt = (cur << ra) | (cur >> (W_AMT - ra));
          ser = nxt[0];
        end
        M_ROR: begin
          nxt = (cur >> ra) | (cur << (W_AMT - ra));
          ser = nxt[WIDTH-1];
        end
        default: begin
          nxt = cur;
          ser = cur_ser;
        end
      endcase
    end
    return {ser, nxt};
  endfunction

  assign idle_start = (state_q == S_IDLE) && start;

  // Manual steps use the live controls; burst steps use the latched ones.
  assign live_step = step_fn(q_q, ser_q, mode,   amt,   ser_in);
  assign run_step  = step_fn(q_q, ser_q, mode_q, amt_q, ser_in);

  // Controller state register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Controller next state: a parallel load always returns to IDLE, which
  // also aborts a running burst without ever visiting FIN.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (load_n && start) state_d = (steps == '0) ? S_FIN : S_RUN;
      end
      S_RUN: begin
        if (!load_n)               state_d = S_IDLE;
        else if (cnt_q == CNT_ONE) state_d = S_FIN;
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Controller outputs decode directly from the state.
  always_comb begin
    busy = (state_q == S_RUN);
    done = (state_q == S_FIN);
  end

  // Datapath next state, in priority order: load, burst start, burst step,
  // manual step. FIN performs no step.
  always_comb begin
    q_d    = q_q;
    ser_d  = ser_q;
    cnt_d  = cnt_q;
    mode_d = mode_q;
    amt_d  = amt_q;
    if (!load_n) begin
      q_d = data_in;
    end else if (idle_start) begin
      mode_d = mode;
      amt_d  = amt;
      cnt_d  = steps;
    end else if (state_q == S_RUN) begin
      q_d   = run_step[WIDTH-1:0];
      ser_d = run_step[WIDTH];
      cnt_d = cnt_q - CNT_ONE;
    end else if ((state_q == S_IDLE) && en) begin
      q_d   = live_step[WIDTH-1:0];
      ser_d = live_step[WIDTH];
    end
  end

  // Register contents, serial output and burst counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      q_q   <= '0;
      ser_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      q_q   <= q_d;
      ser_q <= ser_d;
      cnt_q <= cnt_d;
    end
  end

  // Burst controls captured at start; only meaningful while in RUN.
  always_ff @(posedge clk) begin
    mode_q <= mode_d;
    amt_q  <= amt_d;
  end

  assign q       = q_q;
  assign ser_out = ser_q;

endmodule
